// File: rtl/pb_click_decoder.sv
// Push-button click classifier: turns debounced press pulses and the held level
// into single-click, double-click and long-press one-cycle pulses.
module pb_click_decoder #(
    parameter int LONG_TICKS = 110,
    parameter int GAP_TICKS  = 55
) (
    input  logic       Clk_220Hz,
    input  logic       reset,
    input  logic       press_pulse,
    input  logic       pb_level,
    output logic       single_click,
    output logic       double_click,
    output logic       long_press,
    output logic       busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam logic [7:0] LONG_LAST = 8'(LONG_TICKS - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS - 1);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       single_nx, double_nx, long_nx;

    // State register; pulse outputs are registered alongside the state.
    always_ff @(posedge Clk_220Hz) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            single_click <= single_nx;
            double_click <= double_nx;
            long_press   <= long_nx;
        end
    end

    // Next state; cnt is cleared on every transition so it never wraps.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (press_pulse) begin
                    state_nx = PRESS1;
                    cnt_nx   = 8'd0;
                end
            end
            PRESS1: begin
                if (!pb_level) begin
                    state_nx = GAP;
                    cnt_nx   = 8'd0;
                end else if (cnt == LONG_LAST) begin
                    state_nx = HOLD;
                    cnt_nx   = 8'd0;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            GAP: begin
                if (press_pulse) begin
                    state_nx = PRESS2;
                    cnt_nx   = 8'd0;
                end else if (cnt == GAP_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = 8'd0;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            PRESS2, HOLD: begin
                if (!pb_level) begin
                    state_nx = IDLE;
                    cnt_nx   = 8'd0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    // Pulse decode mirrors exactly the transitions that classify a gesture.
    always_comb begin
        single_nx = (state == GAP) && !press_pulse && (cnt == GAP_LAST);
        double_nx = (state == PRESS2) && !pb_level;
        long_nx   = (state == PRESS1) && pb_level && (cnt == LONG_LAST);
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
